// File: rtl/td_pkg.sv
// ---------------------------------------------------------------------------
// td_pkg
// Shared definitions for the tone detector.
//   td_dir_e   : direction codes, identical to the drive state machine's
//                junction codes (STRAIGHT/LEFT/RIGHT/BACK = 00/01/10/11).
//   td_state_e : encoding of the detector FSM (IDLE, ARMED, VALID, RELEASE).
//   cnt_width  : bits needed for a counter that runs 0..n-1 (minimum 1).
// ---------------------------------------------------------------------------
package td_pkg;

    typedef enum logic [1:0] {
        DIR_STRAIGHT = 2'b00,
        DIR_LEFT     = 2'b01,
        DIR_RIGHT    = 2'b10,
        DIR_BACK     = 2'b11
    } td_dir_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_VALID   = 2'b10,
        ST_RELEASE = 2'b11
    } td_state_e;

    // Width of a counter holding values 0..n-1; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return int'($clog2(n));
    endfunction

endpackage

// File: rtl/tone_qualifier.sv
// ---------------------------------------------------------------------------
// tone_qualifier
// One band-pass comparator channel: 2-flop synchronizer, saturating
// run-length counter and registered qualification flag.
//   clk     : system clock, all logic on posedge
//   rst     : asynchronous active-high reset
//   tone_i  : raw asynchronous comparator output
//   qual_o  : high once the synchronized input has been high for
//             QUAL_CYCLES consecutive cycles; clears on the first low cycle
// Pin-high to qual-high latency is QUAL_CYCLES+2 cycles: two synchronizer
// stages, then QUAL_CYCLES counting cycles with the flag registered on the
// edge where the count reaches QUAL_CYCLES.
// ---------------------------------------------------------------------------
module tone_qualifier
    import td_pkg::*;
#(
    parameter int unsigned QUAL_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic tone_i,
    output logic qual_o
);

    localparam int unsigned     CW      = cnt_width(QUAL_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(QUAL_CYCLES);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          qual_q;
    logic          qual_d;

    // Counter counts synchronized high cycles and parks at CNT_MAX, so a
    // tone held for any length never wraps back below the threshold.
    always_comb begin
        cnt_d = cnt_q;
        if (!sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
        qual_d = sync2_q && (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            qual_q  <= 1'b0;
        end else begin
            sync1_q <= tone_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            qual_q  <= qual_d;
        end
    end

    assign qual_o = qual_q;

endmodule

// File: rtl/tone_detect.sv
// ---------------------------------------------------------------------------
// tone_detect
// Decodes an arm tone (bp5) followed by one direction tone (bp1..bp4) into a
// direction command for the drive state machine.
//   clk          : 50 MHz system clock
//   rst          : asynchronous active-high reset
//   bp1..bp5     : asynchronous comparator outputs
//                  (STRAIGHT, LEFT, RIGHT, BACK, arm)
//   tdAck        : command consumed; only looked at in VALID
//   tdEn         : command valid (registered, high exactly while in VALID)
//   tdDir        : latched direction code, held between commands
//   tdErr        : one-cycle pulse when two or more direction tones qualify
//                  together while armed
//   dbg_state_o  : current FSM state
// Handshake: tdEn/tdDir form a valid/ack pair. Once tdEn rises, tdDir is
// frozen until the command leaves VALID; a cycle with tdEn=1 and tdAck=1
// completes the transfer and tdEn drops on the next edge.
// Configuration macro TD_HOLD_TIMEOUT_EN: when defined, a command that is
// not acknowledged within HOLD_CYCLES cycles is withdrawn (VALID -> RELEASE).
// When undefined, VALID is left only by tdAck or reset and no hold counter
// exists.
// ---------------------------------------------------------------------------
module tone_detect
    import td_pkg::*;
#(
    parameter int unsigned QUAL_CYCLES       = 500_000,
    parameter int unsigned ARM_WINDOW_CYCLES = 50_000_000,
    parameter int unsigned HOLD_CYCLES       = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bp1,
    input  logic       bp2,
    input  logic       bp3,
    input  logic       bp4,
    input  logic       bp5,
    input  logic       tdAck,
    output logic       tdEn,
    output logic [1:0] tdDir,
    output logic       tdErr,
    output td_state_e  dbg_state_o
);

    if (QUAL_CYCLES < 1 || ARM_WINDOW_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_check
        $error("tone_detect: cycle-count parameters must be at least 1");
    end

    localparam int unsigned   WW       = cnt_width(ARM_WINDOW_CYCLES);
    localparam logic [WW-1:0] WIN_LAST = WW'(ARM_WINDOW_CYCLES - 1);

    logic [4:0] bp_vec;
    logic [4:0] qual;

    assign bp_vec = {bp5, bp4, bp3, bp2, bp1};

    for (genvar g = 0; g < 5; g++) begin : g_qual
        tone_qualifier #(
            .QUAL_CYCLES (QUAL_CYCLES)
        ) u_qual (
            .clk    (clk),
            .rst    (rst),
            .tone_i (bp_vec[g]),
            .qual_o (qual[g])
        );
    end

    // Direction decode of qual[3:0]: classify as none / exactly one / several.
    logic    one_dir;
    logic    multi_dir;
    td_dir_e dir_hit;

    always_comb begin
        one_dir   = 1'b0;
        multi_dir = 1'b0;
        dir_hit   = DIR_STRAIGHT;
        case (qual[3:0])
            4'b0000: ;
            4'b0001: begin one_dir = 1'b1; dir_hit = DIR_STRAIGHT; end
            4'b0010: begin one_dir = 1'b1; dir_hit = DIR_LEFT;     end
            4'b0100: begin one_dir = 1'b1; dir_hit = DIR_RIGHT;    end
            4'b1000: begin one_dir = 1'b1; dir_hit = DIR_BACK;     end
            default: multi_dir = 1'b1;
        endcase
    end

    td_state_e     state_q;
    logic          en_q;
    td_dir_e       dir_q;
    logic          err_q;
    logic [WW-1:0] win_q;
    logic          release_req;

`ifdef TD_HOLD_TIMEOUT_EN
    localparam int unsigned   HW        = cnt_width(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [HW-1:0] hold_q;

    // An ack and a timeout landing together still produce a single release.
    assign release_req = tdAck || (hold_q == HOLD_LAST);
`else
    assign release_req = tdAck;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            dir_q   <= DIR_STRAIGHT;
            err_q   <= 1'b0;
            win_q   <= '0;
`ifdef TD_HOLD_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (qual[4]) begin
                        state_q <= ST_ARMED;
                        win_q   <= '0;
                    end
                end
                ST_ARMED: begin
                    // Ambiguity is checked before the window so a collision
                    // on the last window cycle still reports an error.
                    if (multi_dir) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end else if (one_dir) begin
                        state_q <= ST_VALID;
                        en_q    <= 1'b1;
                        dir_q   <= dir_hit;
`ifdef TD_HOLD_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end else if (win_q == WIN_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        win_q <= win_q + WW'(1);
                    end
                end
                ST_VALID: begin
                    if (release_req) begin
                        state_q <= ST_RELEASE;
                        en_q    <= 1'b0;
                    end
`ifdef TD_HOLD_TIMEOUT_EN
                    else begin
                        hold_q <= hold_q + HW'(1);
                    end
`endif
                end
                ST_RELEASE: begin
                    // Wait for every tone to drop so a held tone cannot
                    // immediately re-arm or re-qualify.
                    if (qual == 5'b00000) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tdEn        = en_q;
    assign tdDir       = dir_q;
    assign tdErr       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tone_detect.sv
// ---------------------------------------------------------------------------
// tb_tone_detect
// Directed scenarios followed by randomized tone/ack traffic, checked every
// cycle against a behavioural model of the detector. The model derives the
// qualification flags from a history of sampled pin values and runs the
// command rules with plain integer counters.
// Build with or without TD_HOLD_TIMEOUT_EN; the expectations follow the macro.
// ---------------------------------------------------------------------------
module tb_tone_detect;
    import td_pkg::*;

    localparam int QC = 4;
    localparam int AW = 20;
    localparam int HC = 10;

    logic       clk;
    logic       rst;
    logic       bp1, bp2, bp3, bp4, bp5;
    logic       tdAck;
    logic       tdEn;
    logic [1:0] tdDir;
    logic       tdErr;
    td_state_e  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    tone_detect #(
        .QUAL_CYCLES       (QC),
        .ARM_WINDOW_CYCLES (AW),
        .HOLD_CYCLES       (HC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bp1         (bp1),
        .bp2         (bp2),
        .bp3         (bp3),
        .bp4         (bp4),
        .bp5         (bp5),
        .tdAck       (tdAck),
        .tdEn        (tdEn),
        .tdDir       (tdDir),
        .tdErr       (tdErr),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_hist holds the last QC+2 sampled pin vectors, oldest first. A channel
    // is qualified when it was high on the QC samples that precede the two
    // most recent ones (the synchronizer delay).
    td_state_e  m_state;
    logic       m_en;
    logic [1:0] m_dir;
    logic       m_err;
    int         m_win;
    int         m_hold;
    logic [4:0] m_hist[$];
    logic [4:0] m_qual;
    int         m_ndir;
    logic       m_rel;

    function automatic logic [4:0] hist_qual();
        logic [4:0] q;
        q = 5'b11111;
        for (int i = 0; i < QC; i++) q &= m_hist[i];
        return q;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = ST_IDLE;
            m_en    = 1'b0;
            m_dir   = 2'b00;
            m_err   = 1'b0;
            m_win   = 0;
            m_hold  = 0;
            m_hist.delete();
            for (int i = 0; i < QC + 2; i++) m_hist.push_back(5'b00000);
            m_qual  = 5'b00000;
        end else begin
            m_ndir = $countones(m_qual[3:0]);
            m_err  = 1'b0;
            case (m_state)
                ST_IDLE: begin
                    if (m_qual[4]) begin
                        m_state = ST_ARMED;
                        m_win   = 0;
                    end
                end
                ST_ARMED: begin
                    if (m_ndir >= 2) begin
                        m_state = ST_IDLE;
                        m_err   = 1'b1;
                    end else if (m_ndir == 1) begin
                        m_state = ST_VALID;
                        m_en    = 1'b1;
                        m_hold  = 0;
                        for (int i = 0; i < 4; i++) if (m_qual[i]) m_dir = 2'(i);
                    end else if (m_win == AW - 1) begin
                        m_state = ST_IDLE;
                    end else begin
                        m_win = m_win + 1;
                    end
                end
                ST_VALID: begin
                    m_rel = tdAck;
`ifdef TD_HOLD_TIMEOUT_EN
                    if (m_hold == HC - 1) m_rel = 1'b1;
`endif
                    if (m_rel) begin
                        m_state = ST_RELEASE;
                        m_en    = 1'b0;
                    end else begin
                        m_hold = m_hold + 1;
                    end
                end
                default: begin
                    if (m_qual == 5'b00000) m_state = ST_IDLE;
                end
            endcase
            m_hist.push_back({bp5, bp4, bp3, bp2, bp1});
            void'(m_hist.pop_front());
            m_qual = hist_qual();
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and compare every output to the model.
    task automatic step();
        @(negedge clk);
        chk("tdEn", 32'(tdEn), 32'(m_en));
        chk("tdDir", 32'(tdDir), 32'(m_dir));
        chk("tdErr", 32'(tdErr), 32'(m_err));
        chk("state", 32'(dbg_state), 32'(m_state));
    endtask

    task automatic set_pins(input logic [4:0] v);
        {bp5, bp4, bp3, bp2, bp1} = v;
    endtask

    task automatic wait_state(input td_state_e tgt, input int max_cyc, input string tag);
        int k = 0;
        while (dbg_state !== tgt && k < max_cyc) begin
            step();
            k++;
        end
        chk(tag, 32'(dbg_state), 32'(tgt));
    endtask

    task automatic wait_en(input int max_cyc, input string tag);
        int k = 0;
        while (tdEn !== 1'b1 && k < max_cyc) begin
            step();
            k++;
        end
        chk(tag, 32'(tdEn), 32'd1);
    endtask

    task automatic arm(input string tag);
        set_pins(5'b10000);
        wait_state(ST_ARMED, 20, tag);
        set_pins(5'b00000);
    endtask

    // ---------------- stimulus ----------------
    int lat;
    int cnt;
    int seen;
    logic [4:0] vec;

    initial begin
        rst   = 1'b0;
        tdAck = 1'b0;
        set_pins(5'b00000);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_tdEn", 32'(tdEn), 32'd0);
        chk("reset_tdDir", 32'(tdDir), 32'd0);
        chk("reset_tdErr", 32'(tdErr), 32'd0);
        chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        repeat (3) step();

        // Arm for 8 cycles, then RIGHT; ack retires the command.
        set_pins(5'b10000);
        repeat (8) step();
        set_pins(5'b00100);
        lat = 0;
        while (tdEn !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk("right_en", 32'(tdEn), 32'd1);
        chk("right_latency_ge6", 32'(lat >= 6), 32'd1);
        chk("right_dir", 32'(tdDir), 32'(DIR_RIGHT));
        tdAck = 1'b1;
        step();
        tdAck = 1'b0;
        chk("ack_drops_en", 32'(tdEn), 32'd0);
        set_pins(5'b00000);
        wait_state(ST_IDLE, 20, "right_back_idle");

        // LEFT and BACK together: single error pulse, no command.
        arm("amb_arm");
        set_pins(5'b01010);
        cnt  = 0;
        seen = 0;
        repeat (15) begin
            step();
            if (tdErr === 1'b1) cnt++;
            if (tdEn === 1'b1) seen++;
        end
        chk("amb_err_pulses", 32'(cnt), 32'd1);
        chk("amb_no_en", 32'(seen), 32'd0);
        chk("amb_idle", 32'(dbg_state), 32'(ST_IDLE));
        set_pins(5'b00000);
        repeat (4) step();

        // Window expiry, then a lone STRAIGHT tone must not issue a command.
        arm("win_arm");
        repeat (AW) step();
        chk("win_expired_idle", 32'(dbg_state), 32'(ST_IDLE));
        set_pins(5'b00001);
        seen = 0;
        repeat (12) begin
            step();
            if (tdEn === 1'b1) seen++;
        end
        chk("win_late_dir_no_en", 32'(seen), 32'd0);
        set_pins(5'b00000);
        repeat (4) step();

        // 3-cycle STRAIGHT glitch is rejected, a 4-cycle pulse qualifies.
        arm("glitch_arm");
        set_pins(5'b00001);
        repeat (3) step();
        set_pins(5'b00000);
        seen = 0;
        repeat (6) begin
            step();
            if (tdEn === 1'b1) seen++;
        end
        chk("glitch_no_en", 32'(seen), 32'd0);
        set_pins(5'b00001);
        repeat (4) step();
        set_pins(5'b00000);
        wait_en(10, "pulse4_en");
        chk("pulse4_dir", 32'(tdDir), 32'(DIR_STRAIGHT));
        tdAck = 1'b1;
        step();
        tdAck = 1'b0;
        wait_state(ST_IDLE, 20, "pulse4_idle");

        // Reset in VALID clears outputs at once; held STRAIGHT needs re-arm.
        arm("rst_arm");
        set_pins(5'b01000);
        wait_en(12, "rst_back_en");
        chk("rst_back_dir", 32'(tdDir), 32'(DIR_BACK));
        set_pins(5'b01001);
        repeat (3) step();
        set_pins(5'b00001);
        step();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tdEn", 32'(tdEn), 32'd0);
        chk("async_rst_tdDir", 32'(tdDir), 32'd0);
        chk("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        step();
        step();
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            step();
            if (tdEn === 1'b1) seen++;
        end
        chk("held_tone_no_en", 32'(seen), 32'd0);
        set_pins(5'b10001);
        wait_en(20, "rearm_en");
        chk("rearm_dir", 32'(tdDir), 32'(DIR_STRAIGHT));
        set_pins(5'b00000);
        tdAck = 1'b1;
        step();
        tdAck = 1'b0;
        wait_state(ST_IDLE, 20, "rearm_idle");

        // Unacknowledged command: timeout length depends on the build.
        arm("hold_arm");
        set_pins(5'b00100);
        wait_en(12, "hold_en");
        cnt = 1;
        for (int i = 0; i < 999; i++) begin
            step();
            if (tdEn === 1'b1) cnt++;
        end
`ifdef TD_HOLD_TIMEOUT_EN
        chk("hold_timeout_len", 32'(cnt), 32'd10);
`else
        chk("no_timeout_len", 32'(cnt), 32'd1000);
`endif
        tdAck = 1'b1;
        step();
        tdAck = 1'b0;
        set_pins(5'b00000);
        wait_state(ST_IDLE, 20, "hold_idle");

        // Randomized tones, acks and occasional resets against the model.
        for (int s = 0; s < 200; s++) begin
            for (int b = 0; b < 4; b++) vec[b] = ($urandom_range(0, 3) == 0);
            vec[4] = ($urandom_range(0, 2) == 0);
            set_pins(vec);
            repeat ($urandom_range(1, 14)) begin
                tdAck = ($urandom_range(0, 3) == 0);
                step();
            end
            if ($urandom_range(0, 40) == 0) begin
                #2 rst = 1'b1;
                #1;
                chk("rand_rst_tdEn", 32'(tdEn), 32'd0);
                step();
                rst = 1'b0;
            end
        end
        tdAck = 1'b0;
        set_pins(5'b00000);
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
